// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time, and
// buffers up to two fetched words for decode. A redirect flushes the buffer and the PC.
module instruction_fetch #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_INST_WIDTH = 32,
    parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [BUS_DATA_WIDTH-1:0] imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [BUS_INST_WIDTH-1:0] imem_rdata,
    input  logic                      id_ready,
    input  logic                      redirect_en,
    input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
    output logic [BUS_INST_WIDTH-1:0] inst,
    output logic [BUS_DATA_WIDTH-1:0] IF_PCplus4_out,
    output logic                      if_valid
);

    localparam logic [BUS_INST_WIDTH-1:0] NOP     = BUS_INST_WIDTH'(32'h0100_0000);
    localparam logic [BUS_DATA_WIDTH-1:0] PC_STEP = BUS_DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        DRAIN
    } fetch_state_t;

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic [BUS_DATA_WIDTH-1:0] pc;
    logic [BUS_DATA_WIDTH-1:0] fetch_pcp4;
    logic [1:0]                count;
    logic [BUS_INST_WIDTH-1:0] word_q [2];
    logic [BUS_DATA_WIDTH-1:0] pcp4_q [2];
    logic                      handshake;
    logic                      push;
    logic                      pop;

    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        imem_req   = (state == RUN) && (count < 2'd2) && !reset;
        handshake  = imem_req && imem_gnt;
        pop        = id_ready && (count != 2'd0) && !redirect_en;
        case (state)
            RUN: begin
                // A grant taken in the same cycle as a redirect is already stale.
                if (handshake) begin
                    state_next = redirect_en ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = RUN;
                    push       = !redirect_en;
                end else if (redirect_en) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            count      <= 2'd0;
            fetch_pcp4 <= '0;
        end else begin
            state <= state_next;
            if (redirect_en) begin
                pc <= redirect_pc;
            end else if (handshake) begin
                pc <= pc + PC_STEP;
            end
            if (handshake) begin
                fetch_pcp4 <= pc + PC_STEP;
            end
            if (redirect_en) begin
                count <= 2'd0;
            end else if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Shift-style FIFO: slot 0 is always the head, so a pop moves slot 1 forward
    // and a push lands in the first slot left free after that shift.
    always_ff @(posedge clk) begin
        if (pop) begin
            word_q[0] <= word_q[1];
            pcp4_q[0] <= pcp4_q[1];
        end
        if (push) begin
            if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                word_q[0] <= imem_rdata;
                pcp4_q[0] <= fetch_pcp4;
            end else begin
                word_q[1] <= imem_rdata;
                pcp4_q[1] <= fetch_pcp4;
            end
        end
    end

    assign if_valid       = (count != 2'd0);
    assign inst           = if_valid ? word_q[0] : NOP;
    assign IF_PCplus4_out = if_valid ? pcp4_q[0] : '0;

endmodule
